ocd_scan_master: RTL and testbench

- Host-side initiator for the on-chip-debug virtual-JTAG scan interface.
- Drives tck/tdi, the IR value and the virtual-state strobes (uir, cdr, sdr, udr, rti) into a debug slave's TCK-domain logic, and collects tdo.
- Each accepted command becomes one complete IR-update + DR-scan transaction. The DR bits read back are returned to the requester.
- Used for in-system test of the debug slave and for FPGA-internal debug mastering without a USB-Blaster.

---
 rtl/ocd_scan_master.sv | 201 ++++++++++++++++++++
 tb/tb_ocd_scan_master.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocd_scan_master.sv
// ---------------------------------------------------------------------------
// ocd_scan_master
// Host-side initiator for the on-chip-debug virtual-JTAG scan interface.
// Each accepted command runs one complete transaction:
//   UIR -> CDR -> SDR (DR_WIDTH bits) -> UDR -> RTI -> RSP
// Data goes out on vji_tdi and comes back on vji_tdo, both LSB first. The
// returned DR bits and the IR status sampled during UIR go back to the
// requester through a valid/ready response channel.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ir / cmd_dr are the payload
//   rsp_valid/rsp_ready   response handshake; rsp_dr / rsp_ir_out are the payload
//   vji_tck, vji_tdi      generated scan clock and scan data to the slave
//   vji_tdo               scan data from the slave
//   vji_ir_in/vji_ir_out  instruction to the slave / slave status
//   vji_uir..vji_rti      virtual TAP state strobes
//
// DR_WIDTH must be >= 2 and TCK_DIV must be >= 1.
// ---------------------------------------------------------------------------
module ocd_scan_master #(
    parameter int IR_WIDTH = 2,
    parameter int DR_WIDTH = 38,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int PH_W = $clog2(2 * TCK_DIV);
    localparam int BC_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * TCK_DIV - 1);
    localparam logic [PH_W-1:0] PH_RISE = PH_W'(TCK_DIV);
    localparam logic [PH_W-1:0] PH_PRE_RISE = PH_W'(TCK_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RSP  = 3'd6
    } state_t;

    state_t              state_r;
    logic [PH_W-1:0]     phase_r;
    logic [BC_W-1:0]     bit_cnt_r;
    logic [DR_WIDTH-1:0] shift_r;
    logic                tdo_r;

    logic                scanning_s;
    logic                period_end_s;
    logic                pre_rise_s;
    logic [PH_W-1:0]     phase_next_s;

    // Phase sequencing: the counter only runs while a scan state is active.
    always_comb begin
        scanning_s   = (state_r != ST_IDLE) && (state_r != ST_RSP);
        period_end_s = (phase_r == PH_LAST);
        // Edge at which vji_tck goes high; the slave sees its rising edge here.
        pre_rise_s   = (phase_r == PH_PRE_RISE);
        phase_next_s = {PH_W{1'b0}};
        if (scanning_s && !period_end_s) begin
            phase_next_s = phase_r + {{(PH_W-1){1'b0}}, 1'b1};
        end else begin
            phase_next_s = {PH_W{1'b0}};
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            phase_r    <= {PH_W{1'b0}};
            bit_cnt_r  <= {BC_W{1'b0}};
            shift_r    <= {DR_WIDTH{1'b0}};
            tdo_r      <= 1'b0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_dr     <= {DR_WIDTH{1'b0}};
            rsp_ir_out <= {IR_WIDTH{1'b0}};
            vji_tck    <= 1'b0;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= {IR_WIDTH{1'b0}};
            vji_uir    <= 1'b0;
            vji_cdr    <= 1'b0;
            vji_sdr    <= 1'b0;
            vji_udr    <= 1'b0;
            vji_rti    <= 1'b1;
        end else begin
            phase_r <= phase_next_s;
            // Registered from the next phase so tck always equals (phase >= TCK_DIV).
            vji_tck <= (phase_next_s >= PH_RISE);
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        vji_ir_in <= cmd_ir;
                        shift_r   <= cmd_dr;
                        cmd_ready <= 1'b0;
                        vji_rti   <= 1'b0;
                        vji_uir   <= 1'b1;
                        state_r   <= ST_UIR;
                    end
                end
                ST_UIR: begin
                    if (pre_rise_s) begin
                        rsp_ir_out <= vji_ir_out;
                    end
                    if (period_end_s) begin
                        vji_uir <= 1'b0;
                        vji_cdr <= 1'b1;
                        state_r <= ST_CDR;
                    end
                end
                ST_CDR: begin
                    if (period_end_s) begin
                        vji_cdr <= 1'b0;
                        vji_sdr <= 1'b1;
                        vji_tdi <= shift_r[0];
                        state_r <= ST_SDR;
                    end
                end
                ST_SDR: begin
                    if (pre_rise_s) begin
                        tdo_r <= vji_tdo;
                    end
                    if (period_end_s) begin
                        // Returned bit enters at the MSB; after DR_WIDTH shifts the
                        // first-received bit sits in the LSB.
                        shift_r <= {tdo_r, shift_r[DR_WIDTH-1:1]};
                        if (bit_cnt_r == BC_LAST) begin
                            bit_cnt_r <= {BC_W{1'b0}};
                            vji_tdi   <= 1'b0;
                            vji_sdr   <= 1'b0;
                            vji_udr   <= 1'b1;
                            state_r   <= ST_UDR;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + {{(BC_W-1){1'b0}}, 1'b1};
                            // Next outgoing bit is the one about to move into bit 0.
                            vji_tdi   <= shift_r[1];
                        end
                    end
                end
                ST_UDR: begin
                    if (period_end_s) begin
                        vji_udr <= 1'b0;
                        vji_rti <= 1'b1;
                        state_r <= ST_RTI;
                    end
                end
                ST_RTI: begin
                    if (period_end_s) begin
                        rsp_dr    <= shift_r;
                        rsp_valid <= 1'b1;
                        state_r   <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    vji_tdi   <= 1'b0;
                    vji_uir   <= 1'b0;
                    vji_cdr   <= 1'b0;
                    vji_sdr   <= 1'b0;
                    vji_udr   <= 1'b0;
                    vji_rti   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ocd_scan_master.sv
// ---------------------------------------------------------------------------
// tb_ocd_scan_master
// Two instances: default parameters (IR 2, DR 38, TCK_DIV 2) and a small one
// (DR 8, TCK_DIV 1). Each drives a behavioural scan-chain slave. Expected
// values come from a bit-exchange model of the scan and from the timing rules:
// strobe durations, latency, tck period and reset values.
// ---------------------------------------------------------------------------
module tb_ocd_scan_master;

    localparam int IRW = 2;
    localparam int DRW = 38;
    localparam int DIV = 2;
    localparam int DRW8 = 8;
    localparam int DIV8 = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- default instance ----------------
    logic           cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
    logic [IRW-1:0] cmd_ir = '0, rsp_ir_out, vji_ir_in, vji_ir_out = '0;
    logic [DRW-1:0] cmd_dr = '0, rsp_dr;
    logic           vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    ocd_scan_master #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out), .vji_tck(vji_tck), .vji_tdi(vji_tdi),
        .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
        .vji_rti(vji_rti));

    // ---------------- small instance ----------------
    logic            cmd_valid8 = 1'b0, cmd_ready8, rsp_valid8, rsp_ready8 = 1'b0;
    logic [IRW-1:0]  rsp_ir_out8, vji_ir_in8;
    logic [DRW8-1:0] cmd_dr8 = '0, rsp_dr8;
    logic            tck8, tdi8, tdo8, uir8, cdr8, sdr8, udr8, rti8;

    ocd_scan_master #(.IR_WIDTH(IRW), .DR_WIDTH(DRW8), .TCK_DIV(DIV8)) dut8 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
        .cmd_ir(2'b11), .cmd_dr(cmd_dr8), .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready8),
        .rsp_dr(rsp_dr8), .rsp_ir_out(rsp_ir_out8), .vji_tck(tck8), .vji_tdi(tdi8),
        .vji_tdo(tdo8), .vji_ir_in(vji_ir_in8), .vji_ir_out(2'b01),
        .vji_uir(uir8), .vji_cdr(cdr8), .vji_sdr(sdr8), .vji_udr(udr8), .vji_rti(rti8));

    // ---------------- slave models: plain DR shift chains ----------------
    logic [DRW-1:0]  slv = '0, slv_pre = '0;
    logic [DRW8-1:0] slv8 = '0, slv8_pre = '0;
    logic            slv_load = 1'b0;
    assign vji_tdo = slv[0];
    assign tdo8    = slv8[0];

    always @(posedge vji_tck or posedge slv_load) begin
        if (slv_load) slv <= slv_pre;
        else if (vji_sdr) slv <= {vji_tdi, slv[DRW-1:1]};
    end

    always @(posedge tck8 or posedge slv_load) begin
        if (slv_load) slv8 <= slv8_pre;
        else if (sdr8) slv8 <= {tdi8, slv8[DRW8-1:1]};
    end

    // ---------------- protocol monitor (sampled on falling clk edge) ----------------
    logic           mon_clear = 1'b0;
    logic [IRW-1:0] mon_ir = '0;
    int c_uir, c_cdr, c_sdr, c_udr, rises, viol, cyc;
    int f_uir, f_cdr, f_sdr, f_udr;
    int rises8, last_rise8, viol8;
    logic tck_p, tdi_p, tck8_p;

    always @(negedge clk) begin
        tck_p  <= vji_tck;
        tdi_p  <= vji_tdi;
        tck8_p <= tck8;
        if (mon_clear) begin
            c_uir <= 0; c_cdr <= 0; c_sdr <= 0; c_udr <= 0;
            rises <= 0; viol <= 0; cyc <= 0;
            f_uir <= -1; f_cdr <= -1; f_sdr <= -1; f_udr <= -1;
            rises8 <= 0; last_rise8 <= -1; viol8 <= 0;
        end else begin
            cyc <= cyc + 1;
            if (vji_uir) begin c_uir <= c_uir + 1; if (f_uir < 0) f_uir <= cyc; end
            if (vji_cdr) begin c_cdr <= c_cdr + 1; if (f_cdr < 0) f_cdr <= cyc; end
            if (vji_sdr) begin c_sdr <= c_sdr + 1; if (f_sdr < 0) f_sdr <= cyc; end
            if (vji_udr) begin c_udr <= c_udr + 1; if (f_udr < 0) f_udr <= cyc; end
            // Exactly one of the five state strobes is high at any time.
            if ((32'(vji_uir) + 32'(vji_cdr) + 32'(vji_sdr) + 32'(vji_udr) + 32'(vji_rti)) != 1)
                viol <= viol + 1;
            if ((vji_uir || vji_cdr || vji_sdr || vji_udr) && vji_ir_in !== mon_ir)
                viol <= viol + 1;
            if (!vji_sdr && vji_tdi) viol <= viol + 1;
            if (vji_tck && tck_p && vji_tdi !== tdi_p) viol <= viol + 1;
            if (vji_tck && !tck_p && vji_sdr) rises <= rises + 1;
            if (tck8 && !tck8_p) begin
                if (sdr8) rises8 <= rises8 + 1;
                if (last_rise8 >= 0 && cyc - last_rise8 != 2 * DIV8) viol8 <= viol8 + 1;
                last_rise8 <= cyc;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference scan: bits leave each side LSB first and arrive in order; what
    // arrives first ends up in the LSB of the receiving register.
    function automatic void model_scan(input logic [63:0] m_dr, input logic [63:0] s_pre,
                                       input int n, output logic [63:0] m_rx,
                                       output logic [63:0] s_rx);
        bit mq[$];
        bit sq[$];
        for (int i = 0; i < n; i++) begin
            mq.push_back(m_dr[i]);
            sq.push_back(s_pre[i]);
        end
        m_rx = '0;
        s_rx = '0;
        for (int i = 0; i < n; i++) begin
            m_rx[i] = sq.pop_front();
            s_rx[i] = mq.pop_front();
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clear = 1'b1;
        tick();
        mon_clear = 1'b0;
    endtask

    task automatic preload(input logic [DRW-1:0] p, input logic [DRW8-1:0] p8);
        slv_pre  = p;
        slv8_pre = p8;
        slv_load = 1'b1;
        #1;
        slv_load = 1'b0;
    endtask

    // Full transaction on the default instance, optionally holding the response.
    task automatic run_txn(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                           input logic [DRW-1:0] pre, input logic [IRW-1:0] irout,
                           input bit hold);
        logic [63:0] exp_rsp, exp_slv;
        int lat;
        logic [DRW-1:0] held;
        model_scan(64'(dr), 64'(pre), DRW, exp_rsp, exp_slv);
        preload(pre, slv8_pre);
        vji_ir_out = irout;
        mon_ir     = ir;
        clear_mon();
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_dr    = dr;
        tick();
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 1000) begin
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'((DRW + 4) * 2 * DIV));
        check("rsp_dr", 64'(rsp_dr), exp_rsp);
        check("slave_dr", 64'(slv), exp_slv);
        check("rsp_ir_out", 64'(rsp_ir_out), 64'(irout));
        check("sdr_tck_rises", 64'(rises), 64'(DRW));
        check("uir_cycles", 64'(c_uir), 64'(2 * DIV));
        check("cdr_cycles", 64'(c_cdr), 64'(2 * DIV));
        check("sdr_cycles", 64'(c_sdr), 64'(DRW * 2 * DIV));
        check("udr_cycles", 64'(c_udr), 64'(2 * DIV));
        check("strobe_order", 64'((f_uir < f_cdr) && (f_cdr < f_sdr) && (f_sdr < f_udr)), 64'd1);
        check("protocol_viol", 64'(viol), 64'd0);
        check("busy_cmd_ready", 64'(cmd_ready), 64'd0);
        if (hold) begin
            held      = rsp_dr;
            cmd_valid = 1'b1;
            cmd_ir    = ~ir;
            for (int i = 0; i < 20; i++) begin
                tick();
                check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
                check("hold_rsp_dr", 64'(rsp_dr), 64'(held));
                check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            end
            check("hold_no_uir", 64'(vji_uir), 64'd0);
            cmd_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("consumed_rsp_valid", 64'(rsp_valid), 64'd0);
        check("consumed_cmd_ready", 64'(cmd_ready), 64'd1);
        check("ir_in_held", 64'(vji_ir_in), 64'(ir));
    endtask

    // Start a transaction, reset during SDR bit 17, check the abort.
    task automatic abort_txn();
        int t;
        int seen;
        preload(38'h3F_0F0F_0F0F, slv8_pre);
        mon_ir = 2'b10;
        clear_mon();
        cmd_valid = 1'b1;
        cmd_ir    = 2'b10;
        cmd_dr    = 38'h00_FFFF_0000;
        tick();
        cmd_valid = 1'b0;
        t = 0;
        while (rises < 18 && t < 1000) begin
            tick();
            t++;
        end
        check("abort_reached_bit17", 64'(rises), 64'd18);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_tck", 64'(vji_tck), 64'd0);
        check("abort_sdr", 64'(vji_sdr), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rsp_valid || vji_uir || vji_sdr) seen++;
        end
        check("abort_no_response", 64'(seen), 64'd0);
    endtask

    task automatic run_small(input logic [DRW8-1:0] dr, input logic [DRW8-1:0] pre);
        logic [63:0] exp_rsp, exp_slv;
        int lat;
        model_scan(64'(dr), 64'(pre), DRW8, exp_rsp, exp_slv);
        preload(slv_pre, pre);
        clear_mon();
        check("s_idle_ready", 64'(cmd_ready8), 64'd1);
        cmd_valid8 = 1'b1;
        cmd_dr8    = dr;
        tick();
        cmd_valid8 = 1'b0;
        lat = 0;
        while (!rsp_valid8 && lat < 1000) begin
            tick();
            lat++;
        end
        check("s_latency", 64'(lat), 64'((DRW8 + 4) * 2 * DIV8));
        check("s_rsp_dr", 64'(rsp_dr8), exp_rsp);
        check("s_slave_dr", 64'(slv8), exp_slv);
        check("s_sdr_rises", 64'(rises8), 64'(DRW8));
        check("s_tck_period", 64'(viol8), 64'd0);
        check("s_rsp_ir_out", 64'(rsp_ir_out8), 64'h1);
        rsp_ready8 = 1'b1;
        tick();
        rsp_ready8 = 1'b0;
        check("s_consumed", 64'(rsp_valid8), 64'd0);
    endtask

    task automatic check_reset_values();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_dr", 64'(rsp_dr), 64'd0);
        check("rst_rsp_ir_out", 64'(rsp_ir_out), 64'd0);
        check("rst_tck_tdi", 64'({vji_tck, vji_tdi}), 64'd0);
        check("rst_ir_in", 64'(vji_ir_in), 64'd0);
        check("rst_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'b00001);
    endtask

    initial begin
        logic [DRW-1:0] rdr, rpre;
        logic [IRW-1:0] rir, rirout;
        // Power-up reset
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        check_reset_values();
        tick();

        // Directed transaction from the test plan
        run_txn(2'b01, 38'h15_5555_5555, 38'h2A_1234_5678, 2'b10, 1'b0);

        // Reset held 3 cycles while idle with non-zero outputs
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        check_reset_values();

        // Randomised transactions
        for (int k = 0; k < 3; k++) begin
            rdr    = DRW'({$urandom, $urandom});
            rpre   = DRW'({$urandom, $urandom});
            rir    = IRW'($urandom);
            rirout = IRW'($urandom);
            run_txn(rir, rdr, rpre, rirout, 1'b0);
        end

        // Response back-pressure, then the next command goes through normally
        run_txn(2'b11, 38'h0A_DEAD_BEEF, 38'h35_CAFE_F00D, 2'b01, 1'b1);
        run_txn(2'b00, 38'h3F_FFFF_FFFF, 38'h00_0000_0001, 2'b11, 1'b0);

        // Abort mid-scan, then a clean transaction
        abort_txn();
        run_txn(2'b01, 38'h12_3456_789A, 38'h2B_CDEF_0123, 2'b10, 1'b0);

        // Small instance: TCK_DIV=1, DR_WIDTH=8
        run_small(8'h3C, 8'hC3);
        run_small(DRW8'($urandom), DRW8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
